// File: rtl/irq_controller_banked.sv
// Banked interrupt controller: up to 32 request lines in byte-wide banks with
// per-line edge/level mode, fixed or rotating priority and a post-ack suspend window.
module irq_controller_banked #(
    parameter int NUM_IRQ        = 16,
    parameter int SUSPEND_CYCLES = 31,
    parameter int IA_W           = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               wren,
    input  logic [4:0]         addr,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [7:0]         from_cpu,
    output logic [7:0]         to_cpu,
    output logic [IA_W-1:0]    int_addr,
    output logic               int_rq
);

    localparam int              NUM_BANKS  = (NUM_IRQ + 7) / 8;
    localparam logic [2:0]      NUM_BANKS_L = 3'(NUM_BANKS);
    localparam logic [1:0]      REG_STATUS = 2'd0;
    localparam logic [1:0]      REG_ENABLE = 2'd1;
    localparam logic [1:0]      REG_MODE   = 2'd2;
    localparam logic [1:0]      REG_CFG    = 2'd3;
    localparam logic [7:0]      SUSP_L     = 8'(SUSPEND_CYCLES);
    localparam logic [IA_W:0]   NUM_L      = (IA_W + 1)'(NUM_IRQ);
    localparam logic [IA_W-1:0] LAST_L     = IA_W'(NUM_IRQ - 1);

    logic [NUM_IRQ-1:0] s1_r, s2_r, prev_r;
    logic [NUM_IRQ-1:0] status_r, enable_r, mode_r;
    logic               rotate_r, gen_r;
    logic [7:0]         timer_r;
    logic [1:0]         flush_r;
    logic [IA_W-1:0]    rr_ptr_r;

    logic [2:0]         bank_s;
    logic [1:0]         reg_sel_s;
    logic               bank_ok_s;
    logic               wr_s;
    logic               status_wr_s;
    logic               cfg_wr_s;
    logic [4:0]         byte_base_s;
    logic [31:0]        status_pad_s, enable_pad_s, mode_pad_s;
    logic [31:0]        wmask_pad_s, enable_nx_s, mode_nx_s;
    logic [7:0]         rd_byte_s;
    logic [NUM_IRQ-1:0] trig_s;
    logic [NUM_IRQ-1:0] status_nx_s;
    logic [NUM_IRQ-1:0] pend_s;
    logic               found_s;
    logic [IA_W-1:0]    winner_s;
    logic [IA_W-1:0]    rr_nx_s;

    assign bank_s      = addr[4:2];
    assign reg_sel_s   = addr[1:0];
    assign bank_ok_s   = (bank_s < NUM_BANKS_L);
    assign byte_base_s = {bank_s[1:0], 3'b000};
    assign wr_s        = ce & wren;
    assign status_wr_s = wr_s & (reg_sel_s == REG_STATUS);
    assign cfg_wr_s    = wr_s & (reg_sel_s == REG_CFG) & (bank_s == 3'd0);
    // Level mode passes s2 straight through; edge mode needs a low-to-high step.
    assign trig_s      = s2_r & (mode_r | ~prev_r);
    assign pend_s      = status_r & enable_r;
    assign rr_nx_s     = (int_addr == LAST_L) ? {IA_W{1'b0}} : int_addr + IA_W'(1);

    // Register decode: zero-padded views, read mux and write-merged next values
    always_comb begin
        status_pad_s                = 32'h0;
        enable_pad_s                = 32'h0;
        mode_pad_s                  = 32'h0;
        status_pad_s[NUM_IRQ-1:0]   = status_r;
        enable_pad_s[NUM_IRQ-1:0]   = enable_r;
        mode_pad_s[NUM_IRQ-1:0]     = mode_r;
        wmask_pad_s                 = 32'hFFFF_FFFF;
        enable_nx_s                 = enable_pad_s;
        mode_nx_s                   = mode_pad_s;
        rd_byte_s                   = 8'h00;

        case ({bank_ok_s, reg_sel_s})
            {1'b1, REG_STATUS}: rd_byte_s = status_pad_s[byte_base_s +: 8];
            {1'b1, REG_ENABLE}: rd_byte_s = enable_pad_s[byte_base_s +: 8];
            {1'b1, REG_MODE}:   rd_byte_s = mode_pad_s[byte_base_s +: 8];
            {1'b1, REG_CFG}:    rd_byte_s = (bank_s == 3'd0) ? {6'd0, gen_r, rotate_r} : 8'h00;
            default:            rd_byte_s = 8'h00;
        endcase

        case ({wr_s & bank_ok_s, reg_sel_s})
            {1'b1, REG_STATUS}: wmask_pad_s[byte_base_s +: 8] = from_cpu;
            {1'b1, REG_ENABLE}: enable_nx_s[byte_base_s +: 8] = from_cpu;
            {1'b1, REG_MODE}:   mode_nx_s[byte_base_s +: 8]   = from_cpu;
            default:            wmask_pad_s                   = 32'hFFFF_FFFF;
        endcase

        // A trigger coinciding with a clearing write keeps its bit set.
        status_nx_s = (status_r & wmask_pad_s[NUM_IRQ-1:0]) | trig_s;
    end

    // Priority search starting at rr_ptr (rotating) or at channel 0 (fixed)
    always_comb begin
        logic [IA_W-1:0] base_v;
        logic [IA_W:0]   sum_v;
        logic [IA_W:0]   idx_v;
        found_s  = 1'b0;
        winner_s = {IA_W{1'b0}};
        base_v   = rotate_r ? rr_ptr_r : {IA_W{1'b0}};
        sum_v    = {(IA_W + 1){1'b0}};
        idx_v    = {(IA_W + 1){1'b0}};
        for (int k = 0; k < NUM_IRQ; k++) begin
            sum_v    = {1'b0, base_v} + (IA_W + 1)'(k);
            idx_v    = (sum_v >= NUM_L) ? sum_v - NUM_L : sum_v;
            winner_s = (pend_s[idx_v[IA_W-1:0]] && !found_s) ? idx_v[IA_W-1:0] : winner_s;
            found_s  = found_s | pend_s[idx_v[IA_W-1:0]];
        end
    end

    // Input synchroniser; prev holds ones until s2 carries real post-reset samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r    <= '0;
            s2_r    <= '0;
            prev_r  <= '1;
            flush_r <= 2'd0;
        end else begin
            s1_r    <= irq_in;
            s2_r    <= s1_r;
            prev_r  <= (flush_r == 2'd2) ? s2_r : prev_r;
            flush_r <= (flush_r == 2'd2) ? flush_r : flush_r + 2'd1;
        end
    end

    // Pending, enable, mode and configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_r <= '0;
            enable_r <= '0;
            mode_r   <= '0;
            rotate_r <= 1'b0;
            gen_r    <= 1'b0;
        end else begin
            status_r <= status_nx_s;
            enable_r <= enable_nx_s[NUM_IRQ-1:0];
            mode_r   <= mode_nx_s[NUM_IRQ-1:0];
            if (cfg_wr_s) begin
                rotate_r <= from_cpu[0];
                gen_r    <= from_cpu[1];
            end
        end
    end

    // Suspend window reloaded by every status write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_r <= 8'd0;
        end else if (status_wr_s) begin
            timer_r <= SUSP_L;
        end else if (timer_r != 8'd0) begin
            timer_r <= timer_r - 8'd1;
        end
    end

    // Registered CPU-facing outputs and round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cpu   <= 8'h00;
            int_addr <= {IA_W{1'b0}};
            int_rq   <= 1'b0;
            rr_ptr_r <= {IA_W{1'b0}};
        end else begin
            if (ce) begin
                to_cpu <= rd_byte_s;
            end
            if (found_s) begin
                int_addr <= winner_s;
            end
            int_rq <= gen_r & (timer_r == 8'd0) & found_s;
            if (status_wr_s && rotate_r) begin
                rr_ptr_r <= rr_nx_s;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller_banked.sv
// Self-checking bench for irq_controller_banked: directed scenarios plus random
// bus/request traffic compared every cycle against a per-channel behavioural model.
module tb_irq_controller_banked;

    localparam int N    = 16;
    localparam int SUSP = 31;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          wren = 1'b0;
    logic [4:0]    addr = 5'd0;
    logic [N-1:0]  irq_in = '0;
    logic [7:0]    from_cpu = 8'h00;
    logic [7:0]    to_cpu;
    logic [AW-1:0] int_addr;
    logic          int_rq;

    int n_checks = 0;
    int n_errors = 0;

    irq_controller_banked #(.NUM_IRQ(N), .SUSPEND_CYCLES(SUSP)) dut (
        .clk(clk), .rst(rst), .ce(ce), .wren(wren), .addr(addr),
        .irq_in(irq_in), .from_cpu(from_cpu), .to_cpu(to_cpu),
        .int_addr(int_addr), .int_rq(int_rq)
    );

    always #5 clk = ~clk;

    // Reference model state, one entry per channel
    bit   m_s1[N], m_s2[N], m_prev[N], m_status[N], m_enable[N], m_mode[N];
    bit   m_rot, m_gen, m_rq;
    int   m_timer, m_rr, m_since, m_addr;
    logic [7:0] m_to_cpu;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_prev[i] = 1;
            m_status[i] = 0; m_enable[i] = 0; m_mode[i] = 0;
        end
        m_rot = 0; m_gen = 0; m_rq = 0;
        m_timer = 0; m_rr = 0; m_since = 0; m_addr = 0;
        m_to_cpu = 8'h00;
    endtask

    function automatic logic [7:0] model_read(input int bank, input int rs);
        logic [7:0] v;
        int ch;
        v = 8'h00;
        if (rs == 3) begin
            if (bank == 0) v = {6'd0, m_gen, m_rot};
        end else begin
            for (int b = 0; b < 8; b++) begin
                ch = bank * 8 + b;
                if (ch < N) begin
                    if (rs == 0) v[b] = m_status[ch];
                    else if (rs == 1) v[b] = m_enable[ch];
                    else v[b] = m_mode[ch];
                end
            end
        end
        return v;
    endfunction

    // One clock of the specification's rules, evaluated from pre-edge state.
    task automatic model_step();
        int bank, rs, idx, win;
        bit wr, any;
        bit trig[N];
        logic [7:0] rd;
        bank = int'(addr[4:2]);
        rs   = int'(addr[1:0]);
        wr   = ce && wren;
        rd   = model_read(bank, rs);
        any  = 0;
        win  = 0;
        for (int i = 0; i < N; i++)
            trig[i] = m_mode[i] ? m_s2[i] : (m_s2[i] && !m_prev[i]);
        for (int k = 0; k < N; k++) begin
            idx = m_rot ? (m_rr + k) % N : k;
            if (!any && m_status[idx] && m_enable[idx]) begin
                any = 1;
                win = idx;
            end
        end
        if (wr && rs == 0 && m_rot) m_rr = (m_addr + 1) % N;
        m_rq = m_gen && (m_timer == 0) && any;
        if (any) m_addr = win;
        if (wr && rs == 0) m_timer = SUSP;
        else if (m_timer > 0) m_timer = m_timer - 1;
        for (int i = 0; i < N; i++) begin
            bit hit;
            hit = wr && (i / 8 == bank);
            m_status[i] = (m_status[i] && !(hit && rs == 0 && !from_cpu[i % 8])) || trig[i];
            if (hit && rs == 1) m_enable[i] = from_cpu[i % 8];
            if (hit && rs == 2) m_mode[i] = from_cpu[i % 8];
        end
        if (wr && rs == 3 && bank == 0) begin
            m_rot = from_cpu[0];
            m_gen = from_cpu[1];
        end
        if (ce) m_to_cpu = rd;
        for (int i = 0; i < N; i++) begin
            if (m_since >= 2) m_prev[i] = m_s2[i];
            m_s2[i] = m_s1[i];
            m_s1[i] = irq_in[i];
        end
        if (m_since < 2) m_since++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("int_rq", {31'd0, int_rq}, {31'd0, m_rq});
        check_eq("int_addr", {28'd0, int_addr}, m_addr);
        check_eq("to_cpu", {24'd0, to_cpu}, {24'd0, m_to_cpu});
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
        ce = 1'b1; wren = 1'b1; addr = a; from_cpu = d;
        tick();
        ce = 1'b0; wren = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [7:0] d);
        ce = 1'b1; wren = 1'b0; addr = a;
        tick();
        d = to_cpu;
        ce = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] m);
        irq_in = irq_in | m;
        tick();
        irq_in = irq_in & ~m;
    endtask

    task automatic wait_rq(input int bound);
        for (int i = 0; i < bound && !int_rq; i++) tick();
        check_eq("wait_rq", {31'd0, int_rq}, 32'd1);
    endtask

    initial begin
        logic [7:0] rd;
        model_reset();
        #2;
        check_eq("rst_to_cpu", {24'd0, to_cpu}, 32'd0);
        check_eq("rst_int_addr", {28'd0, int_addr}, 32'd0);
        check_eq("rst_int_rq", {31'd0, int_rq}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;

        // Fixed priority and suspend window
        bus_write(5'h01, 8'hFF);
        bus_write(5'h05, 8'hFF);
        bus_write(5'h03, 8'h02);
        pulse(16'h0208);
        tick(); tick(); tick();
        check_eq("fixed_rq", {31'd0, int_rq}, 32'd1);
        check_eq("fixed_addr", {28'd0, int_addr}, 32'd3);
        bus_write(5'h00, 8'hF7);
        for (int i = 0; i < SUSP; i++) begin
            tick();
            check_eq("suspend_low", {31'd0, int_rq}, 32'd0);
        end
        tick();
        check_eq("after_suspend_rq", {31'd0, int_rq}, 32'd1);
        check_eq("after_suspend_addr", {28'd0, int_addr}, 32'd9);
        bus_write(5'h04, 8'h00);

        // Edge arriving together with a clearing write survives
        pulse(16'h0004);
        tick();
        bus_write(5'h00, 8'hFB);
        bus_read(5'h00, rd);
        check_eq("lost_edge", {31'd0, rd[2]}, 32'd1);
        bus_write(5'h00, 8'h00);

        // Level mode cannot be cleared while the input is high
        bus_write(5'h02, 8'h01);
        irq_in[0] = 1'b1;
        repeat (4) tick();
        bus_write(5'h00, 8'hFE);
        bus_read(5'h00, rd);
        check_eq("level_hold", {31'd0, rd[0]}, 32'd1);
        irq_in[0] = 1'b0;
        repeat (3) tick();
        bus_write(5'h00, 8'hFE);
        bus_read(5'h00, rd);
        check_eq("level_clear", {31'd0, rd[0]}, 32'd0);
        bus_write(5'h02, 8'h00);
        bus_write(5'h00, 8'h00);
        bus_write(5'h04, 8'h00);

        // Rotating priority: grants 1, 5, 12, 1
        bus_write(5'h03, 8'h03);
        pulse(16'h1022);
        wait_rq(80);
        check_eq("rot_g0", {28'd0, int_addr}, 32'd1);
        bus_write(5'h00, 8'hFD);
        pulse(16'h0002);
        wait_rq(80);
        check_eq("rot_g1", {28'd0, int_addr}, 32'd5);
        bus_write(5'h00, 8'hDF);
        pulse(16'h0020);
        wait_rq(80);
        check_eq("rot_g2", {28'd0, int_addr}, 32'd12);
        bus_write(5'h04, 8'hEF);
        pulse(16'h1000);
        wait_rq(80);
        check_eq("rot_g3", {28'd0, int_addr}, 32'd1);

        // Masking and global enable
        bus_write(5'h01, 8'h00);
        bus_write(5'h05, 8'h00);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("masked_rq", {31'd0, int_rq}, 32'd0);
        end
        bus_read(5'h00, rd);
        check_eq("masked_status0", {24'd0, rd}, 32'h22);
        bus_read(5'h04, rd);
        check_eq("masked_status1", {24'd0, rd}, 32'h10);
        bus_write(5'h01, 8'hFF);
        bus_write(5'h05, 8'hFF);
        bus_write(5'h03, 8'h01);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("gen_off_rq", {31'd0, int_rq}, 32'd0);
        end
        bus_write(5'h03, 8'h03);
        wait_rq(20);

        // Asynchronous reset in the middle of a suspend window
        bus_write(5'h00, 8'hFF);
        bus_read(5'h00, rd);
        repeat (4) tick();
        irq_in[7] = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_rq", {31'd0, int_rq}, 32'd0);
        check_eq("async_rst_to_cpu", {24'd0, to_cpu}, 32'd0);
        check_eq("async_rst_addr", {28'd0, int_addr}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        repeat (8) tick();
        bus_read(5'h00, rd);
        check_eq("held_high_no_edge", {24'd0, rd}, 32'd0);
        irq_in[7] = 1'b0;

        // Random traffic against the model
        for (int n = 0; n < 2500; n++) begin
            ce       = ($urandom_range(0, 7) == 0);
            wren     = $urandom_range(0, 1) == 1;
            addr     = 5'($urandom_range(0, 31));
            from_cpu = 8'($urandom);
            if ($urandom_range(0, 9) == 0 && ce && wren) begin
                addr     = 5'h03;
                from_cpu = 8'($urandom_range(0, 3)) | 8'h02;
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) irq_in[i] = ~irq_in[i];
            tick();
        end
        ce = 1'b0; wren = 1'b0; irq_in = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/irq_controller_banked.md
Name: irq_controller_banked

Overview:
- Parametrised successor to the 8-input CPU interrupt controller. Supports up to 32 request lines in byte-wide banks.
- Each line has its own edge/level mode and a 2-flop input synchroniser.
- Priority is selectable between fixed and rotating.
- Requests are not lost when they arrive in the same cycle as a status write.
- Sits on the CPU I/O bus. Drives int_rq and int_addr to the CPU vector logic.

Parameters:
- NUM_IRQ, 16, number of request lines, 1..32. Channel i maps to bank i/8, bit i%8.
- SUSPEND_CYCLES, 31, cycles int_rq is held low after a status write, 1..255.
- IA_W, $clog2(NUM_IRQ) (minimum 1), width of int_addr. Derived; not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ce  in  1  register access strobe
- wren  in  1  write qualifier for ce
- addr  in  5  [4:2] bank 0..3, [1:0] register select
- irq_in  in  NUM_IRQ  asynchronous request inputs
- from_cpu  in  8  write data
- to_cpu  out  8  registered read data
- int_addr  out  IA_W  index of the selected channel
- int_rq  out  1  interrupt request to the CPU

Behaviour:
- Reset (asynchronous, rst=1), all values take effect immediately:
  - status = 0, enable = 0, mode = 0, cfg = 0
  - sync stages = 0, prev = all ones (an input already high at reset does not trigger)
  - timer = 0, rr_ptr = 0
  - to_cpu = 8'h00, int_addr = 0, int_rq = 0
  - Reset mid-operation discards pending requests and the suspend window.
- Register map (reg select = addr[1:0]):
  - 0 STATUS: pending bits for the bank. Write clears: status &= from_cpu.
  - 1 ENABLE: per-channel mask, read/write.
  - 2 MODE: per-channel mode, read/write. 0 = rising edge, 1 = level-high.
  - 3 CFG: meaningful only in bank 0. bit0 ROTATE, bit1 GEN (global enable), other bits read 0. In banks 1..3 it reads 0 and ignores writes.
  - Bits for channels >= NUM_IRQ read 0 and ignore writes. Banks beyond the last read 0 and ignore writes.
- Input path: s1 <= irq_in; s2 <= s1; prev <= s2.
  - Edge mode: trig = s2 & ~prev.
  - Level mode: trig = s2.
- Status update, every cycle: status <= (status & wmask) | trig.
  - wmask = from_cpu for the addressed STATUS bank on a write (ce&wren, reg 0); all ones otherwise.
  - A trig in the same cycle as a clearing write wins, so the bit stays set.
  - A level-mode bit cannot be cleared while its input is high.
- Suspend timer:
  - Any STATUS write (any bank) loads timer = SUSPEND_CYCLES.
  - Otherwise the timer decrements while non-zero.
  - suspend = (timer != 0).
- Reads: when ce=1, to_cpu <= the addressed register on the next edge, for reads and writes alike. When ce=0, to_cpu holds.
- Arbitration: pend = status & enable.
  - ROTATE=0: the lowest set index wins.
  - ROTATE=1: search upward from rr_ptr with wrap-around modulo NUM_IRQ; the first set index wins.
- Outputs, registered each cycle:
  - int_rq <= GEN & ~suspend & |pend.
  - int_addr <= winner when |pend. When pend = 0, int_addr holds its previous value.
- rr_ptr update: on a STATUS write with ROTATE=1, rr_ptr <= (int_addr + 1) mod NUM_IRQ, using the current registered int_addr. rr_ptr is unchanged when ROTATE=0.
- Latency: an input rising before clock edge 1 gives s1 at edge 1, s2 at edge 2, status at edge 3, int_rq=1 at edge 4 (if not suspended).
- NUM_IRQ=1: int_addr is always 0 and rotation has no effect.

Test Plan:
- Fixed priority:
  - Setup: NUM_IRQ=16, GEN=1, ENABLE bank0=8'hFF, bank1=8'hFF.
  - Stimulus: pulse irq_in[9] and irq_in[3] together.
  - Required: int_rq=1 on the 4th edge with int_addr=3. After writing bank0 STATUS 8'hF7, int_rq=0 for 31 cycles, then int_rq=1 with int_addr=9.
- Lost-edge check: pulse irq_in[2] in exactly the cycle its status bit is cleared by a bank0 STATUS write of 8'hFB. Required: status bit2 remains 1 on readback.
- Level mode:
  - Setup: MODE bank0 bit0=1, irq_in[0] held high.
  - Stimulus: write STATUS 8'hFE.
  - Required: readback of status bit0 = 1. After irq_in[0] drops, the next write of 8'hFE leaves bit0 = 0.
- Rotation:
  - Setup: ROTATE=1, channels 1, 5, 12 pending, ENABLE all set.
  - Required: grant sequence 1, 5, 12, 1. Each step is an ack write that clears only the granted bit, then re-pulses it.
- Masking and global enable:
  - ENABLE=0 with status set: int_rq stays 0, while STATUS readback still shows the bit.
  - GEN=0: int_rq stays 0.
- Reset: assert rst asynchronously mid-suspend with bits pending. Required: int_rq, to_cpu and int_addr all go 0 without a clock edge. A high input held through reset produces no edge-mode trigger afterwards.
